// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed scan controller for a row of common-cathode
//                seven-segment digits sharing one external seg7 decoder.
//                Holds a digit register file written through a valid/ready
//                port, alternates BLANK/SHOW slots per digit, applies tear-free
//                updates, PWM brightness and leading-zero suppression.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 250,
  parameter int BLANK_CYCLES = 8,
  localparam int AW = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  lz_en,
  input  logic [3:0]            brightness,
  output logic [3:0]            bcd_out,
  input  logic [6:0]            seg_in,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_tick
);

  // Slot counter must hold the longer of the two slot lengths.
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

  // Scan states
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] slot_cnt;
  logic [AW-1:0] idx;
  logic [3:0]    pwm_cnt;
  logic [3:0]    bright_q;
  logic [3:0]    digits [NUM_DIGITS];

  logic          pending;
  logic [AW-1:0] pend_addr;
  logic [3:0]    pend_data;
  logic          pend_addr_ok;

  logic          blank_end;
  logic          show_end;
  logic          commit_slot;
  logic          zero_from_idx;
  logic          suppress;
  logic          lit;

  assign blank_end   = (state == ST_BLANK) && (slot_cnt == BLANK_LAST);
  assign show_end    = (state == ST_SHOW)  && (slot_cnt == DWELL_LAST);
  // Digit updates land only at the start of a BLANK slot so a lit digit
  // never changes value part-way through its SHOW time.
  assign commit_slot = (state == ST_BLANK) && (slot_cnt == '0);

  // Out-of-range addresses only exist when NUM_DIGITS is not a power of two.
  generate
    if ((1 << AW) == NUM_DIGITS) begin : g_addr_full
      assign pend_addr_ok = 1'b1;
    end else begin : g_addr_partial
      localparam logic [AW:0] NUM_LIM = (AW + 1)'(NUM_DIGITS);
      assign pend_addr_ok = ({1'b0, pend_addr} < NUM_LIM);
    end
  endgenerate

  // Scan sequencer: BLANK gap, then SHOW dwell, then move to the next digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_BLANK;
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (blank_end) begin
            state    <= ST_SHOW;
            slot_cnt <= '0;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        default: begin
          if (show_end) begin
            state    <= ST_BLANK;
            slot_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // PWM phase counter restarts for every SHOW; brightness is frozen per slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt  <= 4'd0;
      bright_q <= 4'd0;
    end else if (blank_end) begin
      pwm_cnt  <= 4'd0;
      bright_q <= brightness;
    end else if (state == ST_SHOW) begin
      pwm_cnt  <= pwm_cnt + 4'd1;
    end
  end

  // Single-entry write buffer: accept when empty, retire at a slot boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      pend_addr <= '0;
      pend_data <= 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits[i] <= 4'd0;
      end
    end else if (pending && commit_slot) begin
      if (pend_addr_ok) begin
        digits[pend_addr] <= pend_data;
      end
      pending <= 1'b0;
    end else if (wr_valid && !pending) begin
      pending   <= 1'b1;
      pend_addr <= wr_addr;
      pend_data <= wr_data;
    end
  end

  // True when the current digit and every more-significant digit are zero.
  always_comb begin
    zero_from_idx = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx)) && (digits[i] != 4'd0)) begin
        zero_from_idx = 1'b0;
      end
    end
  end

  assign suppress = lz_en && (idx != '0) && zero_from_idx;
  assign lit      = (state == ST_SHOW) && !suppress && (pwm_cnt <= bright_q);

  assign wr_ready   = !pending;
  // Decoder input tracks idx through BLANK as well, giving it time to settle.
  assign bcd_out    = digits[idx];
  assign digit_en   = lit ? (NUM_DIGITS'(1) << idx) : '0;
  assign seg_out    = (|digit_en) ? seg_in : 7'd0;
  assign frame_tick = show_end && (idx == IDX_LAST);

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Self-checking bench for seg7_scan_ctrl. A time-based model
//                (position inside frame/slot derived from the cycle number)
//                predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int DW    = 250;
  localparam int BL    = 8;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       lz_en;
  logic [3:0] brightness;
  logic [3:0] bcd_out;
  logic [6:0] seg_in;
  logic [6:0] seg_out;
  logic [3:0] digit_en;
  logic       frame_tick;
  logic [6:0] noise;

  // Second instance with a non-power-of-two digit count for address range.
  logic       wr_valid5;
  logic       wr_ready5;
  logic [2:0] wr_addr5;
  logic [3:0] wr_data5;
  logic [3:0] bcd5;
  logic [6:0] seg_out5;
  logic [4:0] digit_en5;
  logic       tick5;

  always #5 clk = ~clk;

  function automatic logic [6:0] lut(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  assign seg_in = lut(bcd_out) ^ noise;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .lz_en(lz_en), .brightness(brightness),
    .bcd_out(bcd_out), .seg_in(seg_in), .seg_out(seg_out), .digit_en(digit_en),
    .frame_tick(frame_tick)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(5), .DWELL_CYCLES(16), .BLANK_CYCLES(1)) dut5 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid5), .wr_ready(wr_ready5),
    .wr_addr(wr_addr5), .wr_data(wr_data5), .lz_en(1'b0), .brightness(4'hF),
    .bcd_out(bcd5), .seg_in(7'h7F), .seg_out(seg_out5), .digit_en(digit_en5),
    .frame_tick(tick5)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         mt;
  logic [3:0] md [ND];
  bit         mpend;
  int         maddr;
  logic [3:0] mdata;
  logic [3:0] mbq;

  // Values observed in the most recent checked cycle
  logic       last_ready;
  logic [3:0] last_en;
  logic       last_tick;
  logic [3:0] last_bcd;

  typedef struct {
    logic [15:0] digs;
    bit          lz;
    logic [3:0]  br;
    logic [3:0]  mask;
    int          cnt;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, mt);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out (cycle %0d)", nm, mt);
  endtask

  function automatic bit zero_from(input int dg);
    for (int j = dg; j < ND; j++) if (md[j] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    mt = 0; mpend = 0; maddr = 0; mdata = 4'd0; mbq = 4'd0;
    for (int j = 0; j < ND; j++) md[j] = 4'd0;
  endtask

  // One clock cycle: check outputs against the model, advance the model.
  task automatic step();
    int p, dg, w, k;
    bit en;
    @(negedge clk);
    p  = mt % FRAME;
    dg = p / SLOT;
    w  = p % SLOT;
    k  = w - BL;
    en = (w >= BL) && !(lz_en && dg != 0 && zero_from(dg)) && ((k % 16) <= int'(mbq));
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, !mpend});
    chk("bcd_out", {28'd0, bcd_out}, {28'd0, md[dg]});
    chk("digit_en", {28'd0, digit_en}, en ? (32'd1 << dg) : 32'd0);
    chk("seg_out", {25'd0, seg_out}, en ? {25'd0, lut(md[dg]) ^ noise} : 32'd0);
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, (w == SLOT - 1) && (dg == ND - 1)});
    last_ready = wr_ready; last_en = digit_en; last_tick = frame_tick; last_bcd = bcd_out;
    if (mpend && w == 0) begin
      if (maddr < ND) md[maddr] = mdata;
      mpend = 0;
    end else if (!mpend && wr_valid) begin
      mpend = 1; maddr = int'(wr_addr); mdata = wr_data;
    end
    if (w == BL - 1) mbq = brightness;
    mt++;
    @(posedge clk);
    #1 noise = 7'($urandom);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    wr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_digit_en", {28'd0, digit_en}, 32'd0);
    chk("rst_seg_out", {25'd0, seg_out}, 32'd0);
    chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_bcd_out", {28'd0, bcd_out}, 32'd0);
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
  endtask

  task automatic do_write(input int a, input logic [3:0] d);
    bit acc = 0;
    wr_valid = 1'b1; wr_addr = 2'(a); wr_data = d;
    for (int i = 0; i < 2 * SLOT; i++) begin
      acc = !mpend;
      step();
      if (acc) break;
    end
    if (!acc) timeout("write_accept");
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mpend) begin
      step();
      n++;
      if (n > 2 * SLOT) begin timeout("commit"); break; end
    end
  endtask

  task automatic wait_pos(input int pos);
    int n = 0;
    while ((mt % FRAME) != pos) begin
      step();
      n++;
      if (n > FRAME + 1) begin timeout("wait_pos"); break; end
    end
  endtask

  task automatic wr5(input logic [2:0] a, input logic [3:0] d);
    bit ok = 0;
    int n = 0;
    wr_addr5 = a; wr_data5 = d; wr_valid5 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_ready5) begin ok = 1; break; end
      @(posedge clk);
    end
    @(posedge clk);
    #1 wr_valid5 = 1'b0;
    chk("n5_accept", {31'd0, ok}, 32'd1);
    @(negedge clk);
    chk("n5_busy", {31'd0, wr_ready5}, 32'd0);
    while (!wr_ready5) begin
      @(negedge clk);
      n++;
      if (n > 40) begin timeout("n5_ready"); break; end
    end
  endtask

  initial begin
    int rv[$], rl[$], ticks[$];
    logic [3:0] cur;
    int len, t0, cnt, c1, n;
    int cnts [ND];
    vec_t v;

    vt[0] = '{16'h0050, 1'b1, 4'd15, 4'b0011, 250};
    vt[1] = '{16'h0050, 1'b0, 4'd15, 4'b1111, 250};
    vt[2] = '{16'h0000, 1'b1, 4'd3,  4'b0001, 64};
    vt[3] = '{16'h9000, 1'b1, 4'd0,  4'b1111, 16};
    vt[4] = '{16'h0400, 1'b1, 4'd9,  4'b0111, 160};
    vt[5] = '{16'h0007, 1'b1, 4'd12, 4'b0001, 205};
    vt[6] = '{16'hFA00, 1'b0, 4'd15, 4'b1111, 250};

    noise = 7'd0; wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 4'd0;
    lz_en = 1'b0; brightness = 4'd15;
    wr_valid5 = 1'b0; wr_addr5 = 3'd0; wr_data5 = 4'd0;
    m_reset();
    do_reset(3);

    // Basic scan order, slot lengths and frame tick spacing
    cur = 4'd0; len = 0;
    for (int i = 0; i < 2 * FRAME + 40; i++) begin
      step();
      if (last_tick) ticks.push_back(mt - 1);
      if (last_en == cur) len++;
      else begin rv.push_back(int'(cur)); rl.push_back(len); cur = last_en; len = 1; end
    end
    chk("scan_runs", {31'd0, rv.size() >= 9}, 32'd1);
    for (int j = 0; j < 9 && j < rv.size(); j++) begin
      chk("scan_val", rv[j], (j % 2 == 0) ? 0 : (1 << (j / 2)));
      chk("scan_len", rl[j], (j % 2 == 0) ? BL : DW);
    end
    chk("tick_count", ticks.size(), 2);
    if (ticks.size() >= 1) chk("tick_first", ticks[0], FRAME - 1);
    if (ticks.size() >= 2) chk("tick_period", ticks[1] - ticks[0], FRAME);

    // Table: digit pattern, suppression and brightness per frame
    for (int vi = 0; vi < 7; vi++) begin
      v = vt[vi];
      for (int a = 0; a < ND; a++) do_write(a, v.digs[4*a +: 4]);
      wait_idle();
      wait_pos(0);
      lz_en = v.lz; brightness = v.br;
      for (int d = 0; d < ND; d++) cnts[d] = 0;
      for (int i = 0; i < FRAME; i++) begin
        step();
        for (int d = 0; d < ND; d++) if (last_en[d]) cnts[d]++;
      end
      for (int d = 0; d < ND; d++)
        chk($sformatf("vec%0d_on_d%0d", vi, d), cnts[d], v.mask[d] ? v.cnt : 0);
    end

    // Write landing mid-SHOW of the addressed digit
    lz_en = 1'b0; brightness = 4'd15;
    do_write(2, 4'd1);
    wait_idle();
    wait_pos(2 * SLOT + BL + 100);
    t0 = mt;
    do_write(2, 4'd7);
    chk("mid_accept_lat", mt - t0, 1);
    cnt = 0; n = 0;
    while (1) begin
      step();
      if (n == 0) chk("mid_slot_keep", {28'd0, last_bcd}, 32'd1);
      n++;
      if (last_ready) break;
      cnt++;
      if (n > 2 * SLOT) begin timeout("mid_ready"); break; end
    end
    chk("mid_busy_len", cnt, SLOT - (BL + 100));
    wait_pos(2 * SLOT);
    step();
    chk("mid_new_val", {28'd0, last_bcd}, 32'd7);

    // Brightness change part-way through a SHOW slot
    brightness = 4'd3;
    wait_pos(0);
    cnt = 0; c1 = 0;
    for (int i = 0; i < SLOT; i++) begin
      if (i == BL + 40) brightness = 4'd15;
      step();
      if (last_en != 4'd0) cnt++;
    end
    for (int i = 0; i < SLOT; i++) begin
      step();
      if (last_en != 4'd0) c1++;
    end
    chk("pwm_slot_a", cnt, 64);
    chk("pwm_slot_b", c1, 250);

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      wr_valid = ($urandom_range(0, 5) == 0);
      wr_addr  = 2'($urandom);
      wr_data  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
      if ((mt % FRAME) == 0 && $urandom_range(0, 1) == 1) lz_en = ~lz_en;
      step();
    end
    wr_valid = 1'b0;
    wait_idle();

    // Reset while a write is pending mid-SHOW
    lz_en = 1'b0; brightness = 4'd15;
    wait_pos(SLOT + BL + 100);
    do_write(0, 4'd9);
    step();
    chk("rst_pending_busy", {31'd0, last_ready}, 32'd0);
    do_reset(2);
    for (int i = 0; i < SLOT + 20; i++) step();

    // Out-of-range address on a five-digit instance
    wr5(3'd5, 4'd9);
    cnt = 0;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (bcd5 != 4'd0) cnt++;
    end
    chk("n5_oob_nochange", cnt, 0);
    wr5(3'd4, 4'd9);
    cnt = 0;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (bcd5 == 4'd9) cnt++;
    end
    chk("n5_top_digit", cnt, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
